// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int unsigned RX_W_DEF = 10;
  localparam int unsigned TX_W_DEF = 8;

  // Two-bit command field carried in rx_data[RX_W-1 -: 2].
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } spi_state_e;

  // Sub-phase within WRITE / READ_ADD / READ_DATA.
  typedef enum logic [1:0] {
    PhRx,
    PhWait,
    PhTx,
    PhHold
  } spi_phase_e;

  // True in the states that receive a word.
  function automatic logic is_body_state(spi_state_e s);
    return (s == StWrite) || (s == StReadAdd) || (s == StReadData);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with bit counter: serial-in/parallel-out and parallel-load/serial-out.
// Priority: clear, then load, then shift. Shifting is MSB first.
module spi_shift_reg #(
  parameter int unsigned W    = 8,
  parameter int unsigned CntW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic            ser_i,
  input  logic [W-1:0]    par_i,
  output logic [W-1:0]    data_o,
  output logic [CntW-1:0] cnt_o
);

  logic [W-1:0]    data_q;
  logic [CntW-1:0] cnt_q;

  // Data and count update; clear discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= par_i;
      cnt_q  <= '0;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], ser_i};
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises command/data words and shifts RAM read data out on MISO.
// Optional build macro SPI_FRAME_ERR_EN adds frame_err_o, pulsed on a premature SS_n rise.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int unsigned RX_W = RX_W_DEF,
  parameter int unsigned TX_W = TX_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ss_n_i,
  input  logic            mosi_i,
  input  logic [TX_W-1:0] tx_data_i,
  input  logic            tx_valid_i,
  output logic [RX_W-1:0] rx_data_o,
  output logic            rx_valid_o,
`ifdef SPI_FRAME_ERR_EN
  output logic            frame_err_o,
`endif
  output logic            miso_o
);

  localparam int unsigned RxCntW = $clog2(RX_W + 1);
  localparam int unsigned TxCntW = $clog2(TX_W + 1);

  spi_state_e      state_q;
  spi_phase_e      phase_q;
  logic            rd_addr_seen_q;
  logic            rx_valid_q;
  logic [RX_W-1:0] rx_data_q;
`ifdef SPI_FRAME_ERR_EN
  logic            frame_err_q;
`endif

  logic [RX_W-1:0]   rx_par;
  logic [RxCntW-1:0] rx_cnt;
  logic [TX_W-1:0]   tx_par;
  logic [TxCntW-1:0] tx_cnt;
  logic in_body, rx_done, tx_done;
  logic rx_clr, rx_shift, tx_clr, tx_load, tx_shift;
  logic unused_tx;

  // Shift-register control decoded from the current state and SS_n.
  always_comb begin
    in_body  = is_body_state(state_q);
    rx_done  = (rx_cnt == RxCntW'(RX_W));
    tx_done  = (tx_cnt == TxCntW'(TX_W - 1));
    rx_clr   = ss_n_i || (state_q == StIdle);
    rx_shift = !ss_n_i && in_body && (phase_q == PhRx) && !rx_done;
    // TX register doubles as the MISO output flop, so clearing it forces MISO low.
    tx_clr   = ss_n_i || ((phase_q == PhTx) && tx_done);
    tx_load  = !ss_n_i && (state_q == StReadData) && (phase_q == PhWait) && tx_valid_i;
    tx_shift = !ss_n_i && (phase_q == PhTx) && !tx_done;
  end

  spi_shift_reg #(
    .W(RX_W)
  ) u_rx_sr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (rx_clr),
    .load_i (1'b0),
    .shift_i(rx_shift),
    .ser_i  (mosi_i),
    .par_i  ({RX_W{1'b0}}),
    .data_o (rx_par),
    .cnt_o  (rx_cnt)
  );

  spi_shift_reg #(
    .W(TX_W)
  ) u_tx_sr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tx_clr),
    .load_i (tx_load),
    .shift_i(tx_shift),
    .ser_i  (1'b0),
    .par_i  (tx_data_i),
    .data_o (tx_par),
    .cnt_o  (tx_cnt)
  );

  // Frame sequencing plus registered rx_data/rx_valid and frame_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      phase_q        <= PhRx;
      rd_addr_seen_q <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
      if (ss_n_i) begin
`ifdef SPI_FRAME_ERR_EN
        frame_err_q <= in_body && (((phase_q == PhRx) && !rx_done) || (phase_q == PhTx));
`endif
        state_q <= StIdle;
        phase_q <= PhRx;
      end else begin
        case (state_q)
          StIdle: state_q <= StChkCmd;
          StChkCmd: begin
            phase_q <= PhRx;
            if (!mosi_i)             state_q <= StWrite;
            else if (rd_addr_seen_q) state_q <= StReadData;
            else                     state_q <= StReadAdd;
          end
          StWrite, StReadAdd, StReadData: begin
            case (phase_q)
              PhRx: begin
                if (rx_done) begin
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_par;
                  phase_q    <= (state_q == StReadData) ? PhWait : PhHold;
                  if (state_q == StReadAdd) rd_addr_seen_q <= 1'b1;
                end
              end
              PhWait: if (tx_valid_i) phase_q <= PhTx;
              PhTx: begin
                if (tx_done) begin
                  rd_addr_seen_q <= 1'b0;
                  phase_q        <= PhHold;
                end
              end
              default: phase_q <= PhHold;
            endcase
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign miso_o     = tx_par[TX_W-1];
  assign unused_tx  = ^tx_par[TX_W-2:0];
`ifdef SPI_FRAME_ERR_EN
  assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed self-checking bench for spi_slave_fsm (default and SPI_FRAME_ERR_EN builds).
module tb_spi_slave_fsm;

  localparam int unsigned RX_W = 10;
  localparam int unsigned TX_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ss_n;
  logic            mosi;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic            miso;
`ifdef SPI_FRAME_ERR_EN
  logic            frame_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  spi_slave_fsm #(
    .RX_W(RX_W),
    .TX_W(TX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ss_n_i     (ss_n),
    .mosi_i     (mosi),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
`ifdef SPI_FRAME_ERR_EN
    .frame_err_o(frame_err),
`endif
    .miso_o     (miso)
  );

  // Count rx_valid pulses, sampled mid-cycle.
  always @(negedge clk) if (rx_valid) pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame up to one cycle past rx_valid; SS_n is left low.
  task automatic rx_frame(input logic cmd, input logic [RX_W-1:0] w, input string tag);
    int p0;
    ss_n = 1'b0;
    tick();                       // E0: SS_n sampled low
    mosi = cmd;
    tick();                       // E1: command bit
    p0 = pulses;
    for (int i = RX_W - 1; i >= 0; i--) begin
      mosi = w[i];
      tick();                     // E2..E11
    end
    mosi = 1'b0;
    check_eq({tag, "_early"}, 32'(rx_valid), 32'd0);
    tick();                       // E12
    check_eq({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(rx_data), 32'(w));
    check_eq({tag, "_miso"}, 32'(miso), 32'd0);
    tick();                       // E13
    check_eq({tag, "_fall"}, 32'(rx_valid), 32'd0);
    check_eq({tag, "_npulse"}, 32'(pulses - p0), 32'd1);
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    tick();
  endtask

  // Offer read data and confirm MISO never goes high.
  task automatic no_tx(input string tag);
    int highs;
    highs    = 0;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (miso) highs++;
      tick();
    end
    check_eq({tag, "_no_miso"}, 32'(highs), 32'd0);
  endtask

  initial begin
    logic exp_bits [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int p0;
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_miso", 32'(miso), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Write address and write data.
    rx_frame(1'b0, 10'h0A5, "wr_addr");
    end_frame();
    rx_frame(1'b0, 10'h13C, "wr_data");
    end_frame();

    // Read address, then read data with an 8-bit transmit of 0xC3.
    rx_frame(1'b1, 10'h207, "rd_addr");
    end_frame();
    rx_frame(1'b1, 10'h300, "rd_data");
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("tx_bit%0d", i), 32'(miso), 32'(exp_bits[i]));
      tick();
    end
    check_eq("tx_after", 32'(miso), 32'd0);
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    check_eq("tx_retrig", 32'(miso), 32'd0);
    end_frame();

    // Abort a write after 5 payload bits.
    p0   = pulses;
    ss_n = 1'b0;
    tick();
    mosi = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      tick();
    end
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    check_eq("abort_rx_valid", 32'(rx_valid), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check_eq("abort_frame_err", 32'(frame_err), 32'd1);
`endif
    tick();
`ifdef SPI_FRAME_ERR_EN
    check_eq("abort_frame_err_fall", 32'(frame_err), 32'd0);
`endif
    repeat (12) tick();
    check_eq("abort_npulse", 32'(pulses - p0), 32'd0);
    rx_frame(1'b0, 10'h3C3, "wr_after_abort");
    end_frame();

    // rd_addr_seen was cleared by the completed transmit, so this is READ_ADD.
    rx_frame(1'b1, 10'h2AA, "rd_addr2");
    no_tx("rd_addr2");
    end_frame();

    // Reset in the middle of a write; rd_addr_seen must also be cleared.
    ss_n = 1'b0;
    tick();
    mosi = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rx_data", 32'(rx_data), 32'd0);
    check_eq("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("midrst_miso", 32'(miso), 32'd0);
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rx_frame(1'b1, 10'h0F0, "rd_after_rst");
    no_tx("rd_after_rst");
    end_frame();
    rx_frame(1'b0, 10'h155, "wr_after_rst");
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
